hline_zbuff_ctrl: RTL and testbench

//  Burst-based horizontal-line z-buffer controller, successor to the single-transaction hline FSM.

---
 rtl/hline_zbuff_ctrl.sv | 163 ++++++++++++++++
 tb/tb_hline_zbuff_ctrl.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/hline_zbuff_ctrl.sv
// hline_zbuff_ctrl: burst-based horizontal-line z-buffer controller between hline command regs and AXI master
module hline_zbuff_ctrl #(
    parameter int ADDR_W      = 32,
    parameter int Z_W         = 32,
    parameter int X_W         = 16,
    parameter int PIX_BYTES   = 2,
    parameter int BURST_LEN   = 16,
    parameter int LINE_STRIDE = 640
) (
    input  logic                   clk,
    input  logic                   nreset,
    input  logic                   start,
    input  logic [ADDR_W-1:0]      fb_addr,
    input  logic [ADDR_W-1:0]      zbuff_addr,
    input  logic [X_W-1:0]         y,
    input  logic [X_W-1:0]         x1,
    input  logic [X_W-1:0]         x2,
    input  logic [Z_W-1:0]         z1,
    input  logic [Z_W-1:0]         slope,
    input  logic [8*PIX_BYTES-1:0] color,
    input  logic [1:0]             cmp_mode,
    input  logic                   zread_empty,
    input  logic [Z_W-1:0]         zfifo_in,
    input  logic                   axi_done,
    output logic                   busy,
    output logic                   done,
    output logic                   rd_req,
    output logic                   wr_req,
    output logic [ADDR_W-1:0]      addr,
    output logic [8:0]             burst_len,
    output logic                   read_zfifo,
    output logic                   write_zfifo,
    output logic [Z_W-1:0]         z_out,
    output logic                   write_pixfifo,
    output logic [8*PIX_BYTES-1:0] pix_out,
    output logic [PIX_BYTES-1:0]   pix_be
);
    typedef enum logic [2:0] {IDLE, ZRD, CMP, ZWR, FBWR, NXT, FIN} state_t;
    state_t            state;
    logic [ADDR_W-1:0] fb_r;
    logic [ADDR_W-1:0] zb_r;
    logic [X_W-1:0]    y_r;
    logic [X_W-1:0]    x2_r;
    logic [Z_W-1:0]    slope_r;
    logic [1:0]        mode_r;
    logic [X_W:0]      i;
    logic [Z_W-1:0]    zc;
    logic [8:0]        cnt;
    logic              any_pass;
    logic [X_W:0]      span;
    logic [8:0]        to_align;
    logic [8:0]        n;
    logic [X_W:0]      i_next;
    logic [ADDR_W-1:0] pix_idx;
    logic [ADDR_W-1:0] z_addr;
    logic [ADDR_W-1:0] f_addr;
    logic              pass;
    logic              take;
    // burst sizing, addressing and per-pixel depth test for the burst starting at i
    always_comb begin
        span     = {1'b0, x2_r} - i + (X_W+1)'(1);
        to_align = 9'(BURST_LEN) - 9'(i & (X_W+1)'(BURST_LEN-1));
        n        = (span < (X_W+1)'(to_align)) ? span[8:0] : to_align;
        i_next   = i + (X_W+1)'(n);
        pix_idx  = ADDR_W'(y_r) * ADDR_W'(LINE_STRIDE) + ADDR_W'(i);
        z_addr   = zb_r + pix_idx * ADDR_W'(4);
        f_addr   = fb_r + pix_idx * ADDR_W'(PIX_BYTES);
        pass     = mode_r == 2'd0 ? zc < zfifo_in :
                   mode_r == 2'd1 ? zc <= zfifo_in :
                   mode_r == 2'd2 ? zc > zfifo_in : 1'b1;
        take     = state == CMP && (mode_r == 2'd3 || !zread_empty);
    end
    // the pop must coincide with consuming the FIFO head, so it is decoded rather than registered
    assign read_zfifo = take && mode_r != 2'd3;
    assign busy       = state != IDLE;
    assign done       = state == FIN;
    // command sequencing: read old z, compare, write z then pixels, advance to next burst
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state         <= IDLE;
            fb_r          <= '0;
            zb_r          <= '0;
            y_r           <= '0;
            x2_r          <= '0;
            slope_r       <= '0;
            mode_r        <= '0;
            i             <= '0;
            zc            <= '0;
            cnt           <= '0;
            any_pass      <= 1'b0;
            rd_req        <= 1'b0;
            wr_req        <= 1'b0;
            addr          <= '0;
            burst_len     <= '0;
            write_zfifo   <= 1'b0;
            write_pixfifo <= 1'b0;
            z_out         <= '0;
            pix_out       <= '0;
            pix_be        <= '0;
        end else begin
            write_zfifo   <= 1'b0;
            write_pixfifo <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    fb_r     <= fb_addr;
                    zb_r     <= zbuff_addr;
                    y_r      <= y;
                    x2_r     <= x2;
                    slope_r  <= slope;
                    mode_r   <= cmp_mode;
                    pix_out  <= color;
                    i        <= {1'b0, x1};
                    zc       <= z1;
                    cnt      <= '0;
                    any_pass <= 1'b0;
                    state    <= x2 < x1 ? FIN : cmp_mode == 2'd3 ? CMP : ZRD;
                end
                ZRD: if (!rd_req) begin
                    rd_req    <= 1'b1;
                    addr      <= z_addr;
                    burst_len <= n;
                end else if (axi_done) begin
                    rd_req <= 1'b0;
                    state  <= CMP;
                end
                CMP: if (take) begin
                    write_zfifo   <= 1'b1;
                    write_pixfifo <= 1'b1;
                    z_out         <= pass ? zc : zfifo_in;
                    pix_be        <= {PIX_BYTES{pass}};
                    zc            <= zc + slope_r;
                    any_pass      <= any_pass | pass;
                    cnt           <= cnt == n - 9'd1 ? 9'd0 : cnt + 9'd1;
                    if (cnt == n - 9'd1)
                        state <= (any_pass | pass) ? ZWR : NXT;
                end
                ZWR: if (!wr_req) begin
                    wr_req    <= 1'b1;
                    addr      <= z_addr;
                    burst_len <= n;
                end else if (axi_done) begin
                    wr_req <= 1'b0;
                    state  <= FBWR;
                end
                FBWR: if (!wr_req) begin
                    wr_req    <= 1'b1;
                    addr      <= f_addr;
                    burst_len <= n;
                end else if (axi_done) begin
                    wr_req <= 1'b0;
                    state  <= NXT;
                end
                NXT: begin
                    i        <= i_next;
                    any_pass <= 1'b0;
                    state    <= i_next > {1'b0, x2_r} ? FIN : mode_r == 2'd3 ? CMP : ZRD;
                end
                FIN: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_hline_zbuff_ctrl.sv
// tb_hline_zbuff_ctrl: randomized bench with a span-level reference model for hline_zbuff_ctrl
module tb_hline_zbuff_ctrl;
    logic        clk = 0, nreset = 0, start = 0;
    logic [31:0] fb_addr = 0, zbuff_addr = 0, z1 = 0, slope = 0, zfifo_in = 0;
    logic [15:0] y = 0, x1 = 0, x2 = 0, color = 0;
    logic [1:0]  cmp_mode = 0;
    logic        zread_empty = 1, axi_done = 0;
    logic        busy, done, rd_req, wr_req, read_zfifo, write_zfifo, write_pixfifo;
    logic [31:0] addr, z_out;
    logic [8:0]  burst_len;
    logic [15:0] pix_out;
    logic [1:0]  pix_be;

    hline_zbuff_ctrl dut (
        .clk(clk), .nreset(nreset), .start(start), .fb_addr(fb_addr), .zbuff_addr(zbuff_addr),
        .y(y), .x1(x1), .x2(x2), .z1(z1), .slope(slope), .color(color), .cmp_mode(cmp_mode),
        .zread_empty(zread_empty), .zfifo_in(zfifo_in), .axi_done(axi_done), .busy(busy),
        .done(done), .rd_req(rd_req), .wr_req(wr_req), .addr(addr), .burst_len(burst_len),
        .read_zfifo(read_zfifo), .write_zfifo(write_zfifo), .z_out(z_out),
        .write_pixfifo(write_pixfifo), .pix_out(pix_out), .pix_be(pix_be)
    );

    always #5 clk = ~clk;

    typedef struct { bit wr; logic [31:0] a; logic [8:0] len; } txn_t;
    typedef struct { logic [31:0] z; logic [1:0] be; } push_t;
    txn_t        exp_txn[$], txn_log[$];
    push_t       exp_push[$], push_log[$];
    logic [31:0] zq[$];
    int          checks = 0, errors = 0, done_cnt = 0, busy_cycles = 0, cmd_d0 = 0;
    bit          will_pop = 0, prev_req = 0;
    logic [31:0] prev_addr;
    logic [8:0]  prev_len;
    logic [15:0] cur_color;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // FIFO/AXI responder plus per-cycle comparison against the expected queues
    initial begin
        forever begin
            @(negedge clk);
            if (!nreset) begin
                will_pop = 0; axi_done = 0; zread_empty = 1; zfifo_in = 0; prev_req = 0;
            end else begin
                if (will_pop && zq.size() > 0) zq.delete(0);
                zread_empty = (zq.size() == 0) || ($urandom_range(0, 3) == 0);
                zfifo_in = zq.size() > 0 ? zq[0] : $urandom();
                axi_done = (rd_req || wr_req) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 15) == 0);
                #1;
                will_pop = read_zfifo;
                if (busy) busy_cycles++;
                chk("req_exclusive", 64'(rd_req & wr_req), 0);
                chk("pop_when_empty", 64'(read_zfifo & zread_empty), 0);
                chk("push_pair", 64'(write_pixfifo), 64'(write_zfifo));
                if ((rd_req || wr_req) && prev_req) chk("req_stable", {addr, burst_len}, {prev_addr, prev_len});
                prev_req = rd_req || wr_req; prev_addr = addr; prev_len = burst_len;
                if (write_zfifo) begin
                    push_log.push_back('{z_out, pix_be});
                    if (exp_push.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL push_unexpected: got z %0h be %0h expected none", z_out, pix_be);
                    end else begin
                        chk("push_z", z_out, exp_push[0].z);
                        chk("push_be", pix_be, exp_push[0].be);
                        chk("push_pix", pix_out, cur_color);
                        exp_push.delete(0);
                    end
                end
                if (axi_done && (rd_req || wr_req)) begin
                    txn_log.push_back('{wr_req, addr, burst_len});
                    if (exp_txn.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL txn_unexpected: got wr %0d addr %0h len %0d expected none", wr_req, addr, burst_len);
                    end else begin
                        chk("txn_kind", 64'(wr_req), 64'(exp_txn[0].wr));
                        chk("txn_addr", addr, exp_txn[0].a);
                        chk("txn_len", burst_len, exp_txn[0].len);
                        exp_txn.delete(0);
                    end
                end
                if (done) begin
                    done_cnt++;
                    chk("done_pushes_left", 64'(exp_push.size()), 0);
                    chk("done_txns_left", 64'(exp_txn.size()), 0);
                end
            end
        end
    end

    task automatic check_zero(input string tag);
        chk({tag, "_ctl"}, {busy, done, rd_req, wr_req, read_zfifo, write_zfifo, write_pixfifo}, 0);
        chk({tag, "_addr"}, addr, 0);
        chk({tag, "_len"}, burst_len, 0);
        chk({tag, "_zout"}, z_out, 0);
        chk({tag, "_pix"}, {pix_out, pix_be}, 0);
    endtask

    // model: split span into aligned bursts and derive every transaction and push from the rules
    task automatic issue_cmd(input logic [31:0] fb, zb, input int yy, xa, xb, input logic [31:0] z0, sl,
                             input logic [1:0] md, input bit near, input logic [31:0] oldc);
        int x, n;
        logic [31:0] za, fa, nz, oz;
        bit any, p;
        txn_log.delete(); push_log.delete();
        x = xa;
        while (x <= xb) begin
            n = 16 - (x % 16);
            if (xb - x + 1 < n) n = xb - x + 1;
            za = zb + (32'(yy) * 32'd640 + 32'(x)) * 32'd4;
            fa = fb + (32'(yy) * 32'd640 + 32'(x)) * 32'd2;
            any = 0;
            if (md != 3) exp_txn.push_back('{1'b0, za, 9'(n)});
            for (int k = 0; k < n; k++) begin
                nz = z0 + sl * 32'(x + k - xa);
                oz = near ? nz + 32'($urandom_range(0, 4)) - 32'd2 : oldc;
                case (md)
                    2'd0: p = nz < oz;
                    2'd1: p = nz <= oz;
                    2'd2: p = nz > oz;
                    default: p = 1;
                endcase
                if (md != 3) zq.push_back(oz);
                exp_push.push_back('{p ? nz : oz, p ? 2'b11 : 2'b00});
                any |= p;
            end
            if (any) begin
                exp_txn.push_back('{1'b1, za, 9'(n)});
                exp_txn.push_back('{1'b1, fa, 9'(n)});
            end
            x += n;
        end
        @(negedge clk);
        fb_addr = fb; zbuff_addr = zb; y = 16'(yy); x1 = 16'(xa); x2 = 16'(xb);
        z1 = z0; slope = sl; cmp_mode = md; color = 16'($urandom); cur_color = color;
        cmd_d0 = done_cnt; busy_cycles = 0; start = 1;
        @(negedge clk);
        start = 0;
    endtask

    // wait for done; a stray start with scrambled inputs mid-command must be ignored
    task automatic wait_done();
        int t = 0;
        while (done_cnt == cmd_d0 && t < 20000) begin
            if (t == 2 && busy && !done) begin
                start = 1; x1 = 16'($urandom); x2 = 16'($urandom); y = 16'($urandom);
                cmp_mode = 2'($urandom); color = ~color;
            end else start = 0;
            @(negedge clk);
            t++;
        end
        start = 0;
        chk("done_count", 64'(done_cnt - cmd_d0), 1);
    endtask

    task automatic run_cmd(input logic [31:0] fb, zb, input int yy, xa, xb, input logic [31:0] z0, sl,
                           input logic [1:0] md, input bit near, input logic [31:0] oldc);
        issue_cmd(fb, zb, yy, xa, xb, z0, sl, md, near, oldc);
        wait_done();
    endtask

    initial begin
        int cnt, t, xa, ln;
        logic [31:0] rd_a[$];
        #1;
        check_zero("reset");
        repeat (3) @(negedge clk);
        nreset = 1;
        // long LESS span, every pixel passes
        run_cmd(32'h0, 32'h1000_0000, 0, 0, 255, 32'h0, 32'h00FF_FFFF, 2'd0, 0, 32'hFFFF_FFFF);
        rd_a.delete(); cnt = 0;
        foreach (txn_log[k]) if (!txn_log[k].wr) rd_a.push_back(txn_log[k].a);
        foreach (push_log[k]) if (push_log[k].be == 2'b11) cnt++;
        chk("t1_rd_bursts", 64'(rd_a.size()), 16);
        chk("t1_rd_first", rd_a.size() > 0 ? rd_a[0] : 32'hx, 32'h1000_0000);
        chk("t1_rd_last", rd_a.size() > 15 ? rd_a[15] : 32'hx, 32'h1000_03C0);
        chk("t1_all_pass", 64'(cnt), 256);
        // unaligned span split at the 16 boundary
        run_cmd(32'h3000_0000, 32'h2000_0000, 1, 5, 20, 32'h0, 32'h1, 2'd0, 0, 32'hFFFF_FFFF);
        chk("t2_txns", 64'(txn_log.size()), 6);
        chk("t2_rd0", {txn_log[0].wr, txn_log[0].a, txn_log[0].len}, {1'b0, 32'h2000_0A14, 9'd11});
        chk("t2_fb0", {txn_log[2].wr, txn_log[2].a, txn_log[2].len}, {1'b1, 32'h3000_050A, 9'd11});
        chk("t2_rd1", {txn_log[3].wr, txn_log[3].a, txn_log[3].len}, {1'b0, 32'h2000_0A40, 9'd5});
        // GREATER with all old z larger: no writes, pushes carry old z
        run_cmd(32'h0, 32'h0, 4, 32, 47, 32'h100, 32'h1, 2'd2, 0, 32'hFFFF_0000);
        cnt = 0;
        foreach (txn_log[k]) if (txn_log[k].wr) cnt++;
        chk("t3_no_writes", 64'(cnt), 0);
        chk("t3_pushes", 64'(push_log.size()), 16);
        chk("t3_first_push", {push_log[0].z, push_log[0].be}, {32'hFFFF_0000, 2'b00});
        // ALWAYS, single pixel
        run_cmd(32'h3000_0000, 32'h1000_0000, 2, 7, 7, 32'h1234, 32'h5, 2'd3, 0, 32'h0);
        chk("t4_txns", 64'(txn_log.size()), 2);
        chk("t4_zwr", {txn_log[0].wr, txn_log[0].a, txn_log[0].len}, {1'b1, 32'h1000_141C, 9'd1});
        chk("t4_fbwr", {txn_log[1].wr, txn_log[1].a, txn_log[1].len}, {1'b1, 32'h3000_0A0E, 9'd1});
        chk("t4_push", {push_log[0].z, push_log[0].be}, {32'h1234, 2'b11});
        // empty span
        run_cmd(32'h0, 32'h0, 0, 10, 3, 32'h0, 32'h0, 2'd0, 0, 32'h0);
        chk("t5_busy_cycles", 64'(busy_cycles), 1);
        chk("t5_no_activity", 64'(txn_log.size() + push_log.size()), 0);
        // async reset in the middle of CMP, then a clean command
        issue_cmd(32'h0, 32'h0100_0000, 3, 0, 100, 32'h8000_0000, 32'h3, 2'd1, 1, 32'h0);
        t = 0;
        while (push_log.size() < 5 && t < 2000) begin @(negedge clk); t++; end
        chk("t6_reached_cmp", 64'(push_log.size() >= 5), 1);
        #3 nreset = 0;
        #1 check_zero("async_rst");
        exp_txn.delete(); exp_push.delete(); zq.delete();
        repeat (2) @(negedge clk);
        nreset = 1;
        run_cmd(32'h0, 32'h0100_0000, 3, 40, 60, 32'h10, 32'h2, 2'd0, 1, 32'h0);
        chk("t6_restart_rd", {txn_log[0].wr, txn_log[0].a, txn_log[0].len}, {1'b0, 32'h0100_1EA0, 9'd8});
        // randomized commands
        repeat (25) begin
            xa = $urandom_range(0, 639);
            ln = $urandom_range(0, 60);
            run_cmd($urandom(), $urandom(), $urandom_range(0, 479), xa,
                    ln == 0 ? (xa > 0 ? xa - 1 : xa) : xa + ln - 1,
                    $urandom(), 32'($urandom_range(0, 8)) - 32'd4, 2'($urandom_range(0, 3)), 1, 32'h0);
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end
endmodule
